uart_csr_bridge: RTL and testbench
==================================

Name: uart_csr_bridge

Overview:
- Serial-to-CSR bridge: the far end of the UART link from the CSR-mapped UART.
- Receives 8N1 command frames on uart_rx and executes them as CSR reads and writes on the csr_a/csr_we/csr_di/csr_do bus.
- Returns status or read data on uart_tx.
- Used as a host-side debug port, and as a link-partner model in UART testbenches.

Parameters:
- BIT_CYCLES, 16, sys_clk cycles per serial bit; must be >= 4; samples are taken at BIT_CYCLES/2.
- TIMEOUT_BITS, 32, idle bit-times allowed between bytes of one command before the command is abandoned.

Ports:
- sys_clk  input  1  system clock; all logic on posedge.
- sys_rst  input  1  asynchronous, active-low reset.
- uart_rx  input  1  serial command stream; idle high.
- uart_tx  output  1  serial response stream; idle high.
- csr_a  output  14  CSR address.
- csr_we  output  1  CSR write strobe; one-cycle pulse.
- csr_di  output  32  CSR write data.
- csr_do  input  32  CSR read data; valid one cycle after csr_a changes.
- busy  output  1  high from opcode stop-bit acceptance until the response stop bit ends.
- frame_err  output  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset (sys_rst low, async): uart_tx=1, csr_we=0, csr_a=0, csr_di=0, busy=0, frame_err=0. RX and TX engines go idle and the FSM goes to IDLE. A command in flight is discarded with no response.
- RX input: uart_rx passes through a 2-flop synchronizer (2-cycle latency).
- RX start detect:
  - Synchronized falling edge starts the bit counter.
  - At the half-bit point the line must still be low, otherwise it is a false start: ignore and return to hunt.
  - Data bits are sampled LSB first at each mid-bit.
  - Stop bit is sampled at mid-bit. 0 = framing error: pulse frame_err, abort the command, queue response 0x45.
- Byte valid strobe: one cycle, at the stop-bit sample.
- Command format (multi-byte fields big-endian):
  - Write: 0x57, ADDR_H, ADDR_L, D3, D2, D1, D0.
  - Read: 0x52, ADDR_H, ADDR_L.
  - csr_a = {ADDR_H[5:0], ADDR_L}; ADDR_H[7:6] are ignored.
- FSM states: IDLE, ADDR, DATA, CSR_WR, CSR_RD, RD_CAP, RESP.
  - IDLE: 0x57 or 0x52 -> ADDR. Any other byte -> RESP with a single 0x3F.
  - ADDR: after 2 bytes, go to DATA (write) or CSR_RD (read).
  - DATA: after 4 bytes -> CSR_WR.
  - CSR_WR: csr_a and csr_di are driven, csr_we=1 for exactly one cycle, then RESP with 0x4B.
  - CSR_RD: csr_a is driven, csr_we=0.
  - RD_CAP (next cycle): csr_do is latched into the response shift buffer, then RESP with 4 bytes, D3 first.
  - RESP: transmits the queued bytes back-to-back (start, 8 data LSB first, stop; each bit BIT_CYCLES long), then IDLE.
- Latency:
  - csr_we is high in the cycle after the final byte's stop-bit sample.
  - The first response start bit begins in the cycle after CSR_WR or RD_CAP.
- csr_a and csr_di hold their last values between commands.
- Inter-byte timeout: in ADDR or DATA, if no start bit is detected within TIMEOUT_BITS*BIT_CYCLES cycles of the previous stop sample, go to IDLE with no response and no CSR access.
- Bytes arriving while in RESP or CSR states are received but dropped; busy=1 tells the host to wait.
- Framing error:
  - In IDLE: response 0x45.
  - Mid-command: abort, response 0x45, no CSR access.
- A partial write never strobes csr_we.

Test Plan:
- Write: send 57 00 10 DE AD BE EF -> one csr_we pulse with csr_a=0x0010, csr_di=0xDEADBEEF; uart_tx returns 0x4B; busy high throughout.
- Read: send 52 C0 04 with csr_do=0x12345678 one cycle after csr_a=0x0004 -> csr_we stays 0; uart_tx returns 12 34 56 78 in that order; ADDR_H[7:6] are confirmed ignored.
- Bad opcode: send 0xA5 -> uart_tx returns 0x3F; no CSR activity.
- Framing error: send 0x57 with stop bit 0 -> frame_err pulses once, uart_tx returns 0x45, no csr_we.
- Timeout and glitch: send 57 00 then idle 32 bit-times -> no response, next command works. A 2-cycle low glitch on uart_rx is ignored as a false start.
- Reset mid-response: assert sys_rst during a read response -> uart_tx=1 and busy=0 immediately; a following write completes normally.

Source files
------------

// File: rtl/uart_csr_bridge.sv
// UART-to-CSR bridge: decodes 8N1 read/write command frames into CSR bus
// accesses and answers with a status byte or four bytes of read data.
module uart_csr_bridge #(
  parameter int unsigned BIT_CYCLES   = 16,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [13:0] csr_a,
  output logic        csr_we,
  output logic [31:0] csr_di,
  input  logic [31:0] csr_do,
  output logic        busy,
  output logic        frame_err
);
  localparam int unsigned HALF = BIT_CYCLES / 2;
  localparam int unsigned TMO  = TIMEOUT_BITS * BIT_CYCLES;
  localparam int unsigned CW   = $clog2(BIT_CYCLES + 1);
  localparam int unsigned TW   = $clog2(TMO + 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, CSR_WR, CSR_RD, RD_CAP, RESP} state_e;

  state_e        state_q, state_d;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic          rx_active_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          tx_active_q, uart_tx_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic [23:0]   tx_more_q;
  logic [1:0]    tx_rem_q;
  logic [1:0]    byte_cnt_q;
  logic          is_wr_q;
  logic [13:0]   addr_sh_q, csr_a_q;
  logic [23:0]   data_sh_q;
  logic [31:0]   csr_di_q;
  logic [TW-1:0] tmo_q;

  logic rx_fall, rx_smp, rx_stop, rx_valid, rx_ferr;
  logic tx_bit_end, tx_done, tmo_hit, is_op;
  logic        tx_load;
  logic [7:0]  tx_byte;
  logic [23:0] tx_more;
  logic [1:0]  tx_more_n;

  assign rx_fall    = rx_prev_q & ~rx_s2_q;
  assign rx_smp     = rx_active_q &&
                      (rx_cnt_q == ((rx_bit_q == 4'd0) ? CW'(HALF) : CW'(BIT_CYCLES)));
  assign rx_stop    = rx_smp && (rx_bit_q == 4'd9);
  assign rx_valid   = rx_stop & rx_s2_q;
  assign rx_ferr    = rx_stop & ~rx_s2_q;
  assign tx_bit_end = tx_active_q && (tx_cnt_q == CW'(BIT_CYCLES - 1));
  assign tx_done    = tx_bit_end && (tx_bit_q == 4'd9) && (tx_rem_q == 2'd0);
  assign tmo_hit    = (tmo_q == TW'(TMO));
  assign is_op      = (rx_shift_q == 8'h57) || (rx_shift_q == 8'h52);

  assign uart_tx   = uart_tx_q;
  assign csr_a     = csr_a_q;
  assign csr_di    = csr_di_q;
  assign frame_err = rx_ferr;

  // Two-flop synchronizer plus previous-sample register for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // RX engine: start validation at half-bit, then one sample per bit time
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rx_active_q <= 1'b0;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
    end else if (!rx_active_q) begin
      if (rx_fall) begin
        rx_active_q <= 1'b1;
        rx_cnt_q    <= CW'(1);
        rx_bit_q    <= '0;
      end
    end else if (rx_smp) begin
      rx_cnt_q <= CW'(1);
      if (rx_bit_q == 4'd0) begin
        if (rx_s2_q) rx_active_q <= 1'b0;
        else         rx_bit_q    <= 4'd1;
      end else if (rx_bit_q == 4'd9) begin
        rx_active_q <= 1'b0;
      end else begin
        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_q   <= rx_bit_q + 4'd1;
      end
    end else begin
      rx_cnt_q <= rx_cnt_q + CW'(1);
    end
  end

  // TX engine: shifts out the loaded byte, then chains any queued bytes back-to-back
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      tx_active_q <= 1'b0;
      uart_tx_q   <= 1'b1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_more_q   <= '0;
      tx_rem_q    <= '0;
    end else if (tx_load) begin
      tx_active_q <= 1'b1;
      uart_tx_q   <= 1'b0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= tx_byte;
      tx_more_q   <= tx_more;
      tx_rem_q    <= tx_more_n;
    end else if (tx_active_q) begin
      if (!tx_bit_end) begin
        tx_cnt_q <= tx_cnt_q + CW'(1);
      end else begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          if (tx_rem_q != 2'd0) begin
            uart_tx_q  <= 1'b0;
            tx_bit_q   <= '0;
            tx_shift_q <= tx_more_q[23:16];
            tx_more_q  <= {tx_more_q[15:0], 8'h00};
            tx_rem_q   <= tx_rem_q - 2'd1;
          end else begin
            tx_active_q <= 1'b0;
          end
        end else begin
          tx_bit_q <= tx_bit_q + 4'd1;
          if (tx_bit_q == 4'd8) begin
            uart_tx_q <= 1'b1;
          end else begin
            uart_tx_q  <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
          end
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (rx_ferr || rx_valid) state_d = (rx_valid && is_op) ? ADDR : RESP;
      ADDR: begin
        if (rx_ferr)                             state_d = RESP;
        else if (tmo_hit)                        state_d = IDLE;
        else if (rx_valid && byte_cnt_q == 2'd1) state_d = is_wr_q ? DATA : CSR_RD;
      end
      DATA: begin
        if (rx_ferr)                             state_d = RESP;
        else if (tmo_hit)                        state_d = IDLE;
        else if (rx_valid && byte_cnt_q == 2'd3) state_d = CSR_WR;
      end
      CSR_WR: state_d = RESP;
      CSR_RD: state_d = RD_CAP;
      RD_CAP: state_d = RESP;
      RESP:   if (tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: CSR strobe, busy flag and response loads into the TX engine
  always_comb begin
    csr_we    = (state_q == CSR_WR);
    busy      = (state_q != IDLE);
    tx_load   = 1'b0;
    tx_byte   = '0;
    tx_more   = '0;
    tx_more_n = '0;
    case (state_q)
      IDLE: begin
        if (rx_ferr) begin
          tx_load = 1'b1;
          tx_byte = 8'h45;
        end else if (rx_valid && !is_op) begin
          tx_load = 1'b1;
          tx_byte = 8'h3F;
        end
      end
      ADDR, DATA: begin
        if (rx_ferr) begin
          tx_load = 1'b1;
          tx_byte = 8'h45;
        end
      end
      CSR_WR: begin
        tx_load = 1'b1;
        tx_byte = 8'h4B;
      end
      RD_CAP: begin
        tx_load   = 1'b1;
        tx_byte   = csr_do[31:24];
        tx_more   = csr_do[23:0];
        tx_more_n = 2'd3;
      end
      default: ;
    endcase
  end

  // Command field collection; CSR address/data only update when an access is issued
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      byte_cnt_q <= '0;
      is_wr_q    <= 1'b0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      csr_a_q    <= '0;
      csr_di_q   <= '0;
      tmo_q      <= '0;
    end else begin
      if (state_q == IDLE)
        byte_cnt_q <= '0;
      else if (rx_valid && (state_q == ADDR || state_q == DATA))
        byte_cnt_q <= (state_d != state_q) ? 2'd0 : byte_cnt_q + 2'd1;
      if (state_q == IDLE && rx_valid) is_wr_q <= (rx_shift_q == 8'h57);
      if (state_q == ADDR && rx_valid) addr_sh_q <= {addr_sh_q[5:0], rx_shift_q};
      if (state_q == DATA && rx_valid) data_sh_q <= {data_sh_q[15:0], rx_shift_q};
      if (state_q == ADDR && state_d == CSR_RD) csr_a_q <= {addr_sh_q[5:0], rx_shift_q};
      if (state_q == DATA && state_d == CSR_WR) begin
        csr_a_q  <= addr_sh_q;
        csr_di_q <= {data_sh_q, rx_shift_q};
      end
      if ((state_q == ADDR || state_q == DATA) && !rx_active_q && !rx_fall)
        tmo_q <= tmo_q + TW'(1);
      else
        tmo_q <= '0;
    end
  end

endmodule

// File: tb/tb_uart_csr_bridge.sv
// Bench for uart_csr_bridge: serial command driver, serial response monitor,
// CSR slave memory and a command-level reference model.
module tb_uart_csr_bridge;
  localparam int unsigned BC = 16;
  localparam int unsigned TB = 32;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        busy;
  logic        frame_err;

  int unsigned n_chk = 0, n_pass = 0, cyc = 0;
  int unsigned we_cyc = 0, ferr_cnt = 0, rst_epoch = 0, tx_bad = 0;

  logic [7:0]  rxq[$];
  int unsigned txs_q[$];
  logic [45:0] we_q[$];
  logic [8:0]  cmd_q[$];
  logic [7:0]  exp_resp[$];
  logic [45:0] exp_we[$];
  logic [31:0] slave_mem[int];
  logic [31:0] model_mem[int];
  logic [13:0] written[$];

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  uart_csr_bridge #(.BIT_CYCLES(BC), .TIMEOUT_BITS(TB)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do),
    .busy(busy), .frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] def_val(input logic [13:0] a);
    return {a, a, 4'h5} ^ 32'h5A5A_3C3C;
  endfunction

  // CSR slave: read data registered one cycle after the address
  always @(posedge sys_clk) begin
    csr_do <= slave_mem.exists(int'(csr_a)) ? slave_mem[int'(csr_a)] : def_val(csr_a);
    if (csr_we) slave_mem[int'(csr_a)] = csr_di;
  end

  always @(negedge sys_clk) begin
    if (csr_we) begin
      we_q.push_back({csr_a, csr_di});
      we_cyc = cyc;
    end
    if (frame_err) ferr_cnt++;
  end

  always @(negedge sys_rst) rst_epoch++;

  // Serial response decoder; frames cut short by reset are discarded
  initial begin : tx_mon
    logic [7:0]  b;
    int unsigned ep, sc;
    logic        ok;
    forever begin
      @(negedge sys_clk);
      if (sys_rst && uart_tx === 1'b0) begin
        ep = rst_epoch; sc = cyc; ok = 1'b1;
        repeat (BC/2) @(negedge sys_clk);
        if (uart_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (BC) @(negedge sys_clk);
          b[i] = uart_tx;
        end
        repeat (BC) @(negedge sys_clk);
        if (uart_tx !== 1'b1) ok = 1'b0;
        if (ep == rst_epoch) begin
          if (ok) begin rxq.push_back(b); txs_q.push_back(sc); end
          else tx_bad++;
        end
      end
    end
  end

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (BC) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    uart_rx = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (busy !== 1'b0 && n < 200*BC) begin
      @(negedge sys_clk);
      n++;
    end
    chk($sformatf("%s_idle", tag), busy, 0);
    repeat (2*BC) @(negedge sys_clk);
  endtask

  task automatic do_cmd(input string tag, input int unsigned hold_bits, input logic exp_busy);
    rxq.delete(); we_q.delete(); txs_q.delete();
    foreach (cmd_q[i]) begin
      if (i != 0) repeat ($urandom_range(0, 2)) drive_bit(1'b1);
      send_byte(cmd_q[i][7:0], cmd_q[i][8]);
    end
    repeat (hold_bits*BC) @(negedge sys_clk);
    chk($sformatf("%s_busy", tag), busy, exp_busy);
    wait_idle(tag);
    chk($sformatf("%s_nresp", tag), rxq.size(), exp_resp.size());
    for (int i = 0; i < exp_resp.size() && i < rxq.size(); i++)
      chk($sformatf("%s_resp%0d", tag, i), rxq[i], exp_resp[i]);
    chk($sformatf("%s_nwe", tag), we_q.size(), exp_we.size());
    for (int i = 0; i < exp_we.size() && i < we_q.size(); i++)
      chk($sformatf("%s_we%0d", tag, i), we_q[i], exp_we[i]);
  endtask

  task automatic new_cmd();
    cmd_q.delete(); exp_resp.delete(); exp_we.delete();
  endtask

  task automatic model_write(input logic [15:0] a16, input logic [31:0] d);
    new_cmd();
    cmd_q = '{9'h157, {1'b1, a16[15:8]}, {1'b1, a16[7:0]}, {1'b1, d[31:24]},
              {1'b1, d[23:16]}, {1'b1, d[15:8]}, {1'b1, d[7:0]}};
    model_mem[int'(a16[13:0])] = d;
    written.push_back(a16[13:0]);
    exp_resp.push_back(8'h4B);
    exp_we.push_back({a16[13:0], d});
  endtask

  task automatic model_read(input logic [15:0] a16);
    logic [31:0] d;
    new_cmd();
    cmd_q = '{9'h152, {1'b1, a16[15:8]}, {1'b1, a16[7:0]}};
    d = model_mem.exists(int'(a16[13:0])) ? model_mem[int'(a16[13:0])] : def_val(a16[13:0]);
    exp_resp = '{d[31:24], d[23:16], d[15:8], d[7:0]};
  endtask

  initial begin : main
    int unsigned f0, n;
    logic [7:0]  op;
    logic [15:0] a16;

    repeat (5) @(negedge sys_clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_csr_we", csr_we, 0);
    chk("rst_csr_a", csr_a, 0);
    chk("rst_csr_di", csr_di, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    sys_rst = 1'b1;
    repeat (3*BC) @(negedge sys_clk);

    model_write(16'h0010, 32'hDEADBEEF);
    do_cmd("wr", 0, 1'b1);
    chk("wr_latency", (txs_q.size() > 0) ? 64'(txs_q[0] - we_cyc) : 64'd0, 64'd1);

    slave_mem[4] = 32'h12345678;
    model_mem[4] = 32'h12345678;
    model_read(16'hC004);
    do_cmd("rd", 0, 1'b1);

    new_cmd();
    cmd_q.push_back(9'h1A5);
    exp_resp.push_back(8'h3F);
    do_cmd("badop", 0, 1'b1);
    chk("hold_csr_a", csr_a, 14'h0004);
    chk("hold_csr_di", csr_di, 32'hDEADBEEF);

    f0 = ferr_cnt;
    new_cmd();
    cmd_q.push_back(9'h057);
    exp_resp.push_back(8'h45);
    do_cmd("ferr_idle", 0, 1'b1);
    chk("ferr_idle_pulses", ferr_cnt - f0, 1);

    f0 = ferr_cnt;
    new_cmd();
    cmd_q = '{9'h152, 9'h000};
    exp_resp.push_back(8'h45);
    do_cmd("ferr_mid", 0, 1'b1);
    chk("ferr_mid_pulses", ferr_cnt - f0, 1);

    new_cmd();
    cmd_q = '{9'h157, 9'h100};
    do_cmd("timeout", 30, 1'b1);

    rxq.delete();
    f0 = ferr_cnt;
    uart_rx = 1'b0;
    repeat (2) @(negedge sys_clk);
    uart_rx = 1'b1;
    repeat (3*BC) @(negedge sys_clk);
    chk("glitch_busy", busy, 0);
    chk("glitch_resp", rxq.size(), 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);

    for (int k = 0; k < 20; k++) begin
      n = $urandom_range(0, 9);
      a16 = 16'($urandom);
      if (n < 4) begin
        model_write(a16, $urandom);
      end else if (n < 8) begin
        if (written.size() > 0 && $urandom_range(0, 1) == 1)
          a16[13:0] = written[$urandom_range(0, written.size() - 1)];
        model_read(a16);
      end else begin
        op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
        new_cmd();
        cmd_q.push_back({1'b1, op});
        exp_resp.push_back(8'h3F);
      end
      do_cmd($sformatf("rnd%0d", k), 0, 1'b1);
    end

    model_read(16'h0004);
    rxq.delete(); txs_q.delete();
    foreach (cmd_q[i]) send_byte(cmd_q[i][7:0], cmd_q[i][8]);
    n = 0;
    while (txs_q.size() == 0 && n < 100*BC) begin
      @(negedge sys_clk);
      n++;
    end
    chk("rstmid_started", txs_q.size(), 1);
    repeat (12*BC) @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    chk("rstmid_uart_tx", uart_tx, 1);
    chk("rstmid_busy", busy, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2*BC) @(negedge sys_clk);
    model_write(16'h2ABC, 32'hCAFEF00D);
    do_cmd("after_rst", 0, 1'b1);

    chk("tx_framing", tx_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #20ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
